// File: rtl/ghostbus_arb2.sv
// ghostbus_arb2: two-requester round-robin arbiter onto a single shared
// register bus. One transaction at a time.
//   write: IDLE -> ISSUE -> IDLE
//   read : IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> DONE -> IDLE
// Every output is registered, so each output register is loaded from the
// next-state decode and lines up exactly with the state it belongs to.
//
// State table
//   state | meaning
//   IDLE  | sample requests, pick winner, latch its command onto bus_addr/wdata
//   ISSUE | one-cycle bus strobe (we or re) and ack to the winner
//   WAIT  | read in flight, down-counter runs RD_LAT cycles, captures on last
//   DONE  | one-cycle rvalid to the winner with the captured read data
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   mN_req/we/addr/wdata  : requester N command (N = 0, 1), held until ack
//   mN_ack                : one-cycle accept pulse (ISSUE cycle)
//   mN_rvalid/mN_rdata    : one-cycle read completion, rdata holds afterwards
//   bus_addr/wdata/we/re  : shared bus command, strobes only in ISSUE
//   bus_rdata             : shared bus read data, valid RD_LAT cycles after re
//   busy                  : high whenever the FSM is not in IDLE
module ghostbus_arb2 #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_we,
    output logic          bus_re,
    input  logic [DW-1:0] bus_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // WAIT terminates when the counter reaches zero, so load RD_LAT-1.
    localparam logic [3:0] LP_CNT_INIT = 4'(RD_LAT - 1);

    state_t        r_state, w_state_nxt;
    logic          r_last, w_last_nxt;     // last granted requester
    logic          r_win, w_win_nxt;       // current transaction owner
    logic          r_we, w_we_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [AW-1:0] r_bus_addr, w_bus_addr_nxt;
    logic [DW-1:0] r_bus_wdata, w_bus_wdata_nxt;
    logic [DW-1:0] r_m0_rdata, w_m0_rdata_nxt;
    logic [DW-1:0] r_m1_rdata, w_m1_rdata_nxt;
    logic          r_bus_we, w_bus_we_nxt;
    logic          r_bus_re, w_bus_re_nxt;
    logic          r_m0_ack, w_m0_ack_nxt;
    logic          r_m1_ack, w_m1_ack_nxt;
    logic          r_m0_rvalid, w_m0_rvalid_nxt;
    logic          r_m1_rvalid, w_m1_rvalid_nxt;
    logic          r_busy, w_busy_nxt;
    logic          w_issue_nxt;
    logic          w_done_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_win_nxt       = r_win;
        w_we_nxt        = r_we;
        w_cnt_nxt       = r_cnt;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_m0_rdata_nxt  = r_m0_rdata;
        w_m1_rdata_nxt  = r_m1_rdata;

        case (r_state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the requester not granted last wins.
                    w_win_nxt       = (m0_req && m1_req) ? ~r_last : m1_req;
                    w_last_nxt      = w_win_nxt;
                    w_we_nxt        = w_win_nxt ? m1_we    : m0_we;
                    w_bus_addr_nxt  = w_win_nxt ? m1_addr  : m0_addr;
                    w_bus_wdata_nxt = w_win_nxt ? m1_wdata : m0_wdata;
                    w_state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (r_we) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = LP_CNT_INIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = DONE;
                    if (r_win) begin
                        w_m1_rdata_nxt = bus_rdata;
                    end else begin
                        w_m0_rdata_nxt = bus_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_issue_nxt     = (w_state_nxt == ISSUE);
        w_done_nxt      = (w_state_nxt == DONE);
        w_bus_we_nxt    = w_issue_nxt &  w_we_nxt;
        w_bus_re_nxt    = w_issue_nxt & ~w_we_nxt;
        w_m0_ack_nxt    = w_issue_nxt & ~w_win_nxt;
        w_m1_ack_nxt    = w_issue_nxt &  w_win_nxt;
        w_m0_rvalid_nxt = w_done_nxt  & ~w_win_nxt;
        w_m1_rvalid_nxt = w_done_nxt  &  w_win_nxt;
        w_busy_nxt      = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;   // m0 wins the first tie
            r_win       <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= 4'd0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_bus_we    <= 1'b0;
            r_bus_re    <= 1'b0;
            r_m0_ack    <= 1'b0;
            r_m1_ack    <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_win       <= w_win_nxt;
            r_we        <= w_we_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_m0_rdata  <= w_m0_rdata_nxt;
            r_m1_rdata  <= w_m1_rdata_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_re    <= w_bus_re_nxt;
            r_m0_ack    <= w_m0_ack_nxt;
            r_m1_ack    <= w_m1_ack_nxt;
            r_m0_rvalid <= w_m0_rvalid_nxt;
            r_m1_rvalid <= w_m1_rvalid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_we    = r_bus_we;
    assign bus_re    = r_bus_re;
    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ghostbus_arb2.sv
// Bench for ghostbus_arb2: two instances (RD_LAT = 1 and 4) share one
// stimulus stream. The reference model is a transaction timeline: a grant
// at cycle c schedules ack at c+1, rvalid at c+2+lat and the next free
// arbitration cycle, and every output is derived from that schedule.
module tb_ghostbus_arb2;
    localparam int AW = 24;
    localparam int DW = 32;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic          rst;
    logic          m_req    [2][2];
    logic          m_we     [2][2];
    logic [AW-1:0] m_addr   [2][2];
    logic [DW-1:0] m_wdata  [2][2];
    logic          m_ack    [2][2];
    logic          m_rvalid [2][2];
    logic [DW-1:0] m_rdata  [2][2];
    logic [AW-1:0] bus_addr [2];
    logic [DW-1:0] bus_wdata[2];
    logic [DW-1:0] bus_rdata[2];
    logic          bus_we   [2];
    logic          bus_re   [2];
    logic          busy     [2];

    ghostbus_arb2 #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .m0_req(m_req[0][0]), .m0_we(m_we[0][0]), .m0_addr(m_addr[0][0]), .m0_wdata(m_wdata[0][0]),
        .m0_ack(m_ack[0][0]), .m0_rvalid(m_rvalid[0][0]), .m0_rdata(m_rdata[0][0]),
        .m1_req(m_req[0][1]), .m1_we(m_we[0][1]), .m1_addr(m_addr[0][1]), .m1_wdata(m_wdata[0][1]),
        .m1_ack(m_ack[0][1]), .m1_rvalid(m_rvalid[0][1]), .m1_rdata(m_rdata[0][1]),
        .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]), .bus_we(bus_we[0]), .bus_re(bus_re[0]),
        .bus_rdata(bus_rdata[0]), .busy(busy[0])
    );

    ghostbus_arb2 #(.AW(AW), .DW(DW), .RD_LAT(4)) u_dut_l4 (
        .clk(clk), .rst(rst),
        .m0_req(m_req[1][0]), .m0_we(m_we[1][0]), .m0_addr(m_addr[1][0]), .m0_wdata(m_wdata[1][0]),
        .m0_ack(m_ack[1][0]), .m0_rvalid(m_rvalid[1][0]), .m0_rdata(m_rdata[1][0]),
        .m1_req(m_req[1][1]), .m1_we(m_we[1][1]), .m1_addr(m_addr[1][1]), .m1_wdata(m_wdata[1][1]),
        .m1_ack(m_ack[1][1]), .m1_rvalid(m_rvalid[1][1]), .m1_rdata(m_rdata[1][1]),
        .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]), .bus_we(bus_we[1]), .bus_re(bus_re[1]),
        .bus_rdata(bus_rdata[1]), .busy(busy[1])
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sva
            a_excl: assert property (@(posedge clk) !(bus_we[gi] && bus_re[gi]))
                else $error("FAIL sva_we_re_excl inst=%0d", gi);
            a_ack0: assert property (@(posedge clk) disable iff (rst)
                        m_ack[gi][0] |-> $past(m_req[gi][0] && !busy[gi]))
                else $error("FAIL sva_ack0_no_req inst=%0d", gi);
            a_ack1: assert property (@(posedge clk) disable iff (rst)
                        m_ack[gi][1] |-> $past(m_req[gi][1] && !busy[gi]))
                else $error("FAIL sva_ack1_no_req inst=%0d", gi);
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 0;
    bit rst_seen = 0;

    // reference model state, one timeline per instance
    int            lat      [2];
    int            ack_cyc  [2];
    int            done_cyc [2];
    int            idle_cyc [2];
    bit            win      [2];
    bit            wwe      [2];
    bit            last     [2];
    logic [DW-1:0] e_rdata  [2][2];
    logic [AW-1:0] e_addr   [2];
    logic [DW-1:0] e_wdata  [2];
    bit            saw_ack  [2][2];

    int g_seq[2][$];
    int busy_cnt, rv_at, ack0_at;
    bit idle7;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset(input int i);
        ack_cyc[i]    = -100;
        done_cyc[i]   = -100;
        idle_cyc[i]   = 0;
        last[i]       = 1'b1;
        win[i]        = 1'b0;
        wwe[i]        = 1'b0;
        e_rdata[i][0] = '0;
        e_rdata[i][1] = '0;
        e_addr[i]     = '0;
        e_wdata[i]    = '0;
    endtask

    task automatic check_cycle();
        for (int i = 0; i < 2; i++) begin
            bit issue, e_busy, done;
            issue  = (cyc == ack_cyc[i]);
            done   = !wwe[i] && (cyc == done_cyc[i]);
            e_busy = (cyc >= ack_cyc[i]) && (cyc < idle_cyc[i]);
            chk($sformatf("i%0d_busy", i),      32'(busy[i]),      32'(e_busy));
            chk($sformatf("i%0d_bus_we", i),    32'(bus_we[i]),    32'(issue && wwe[i]));
            chk($sformatf("i%0d_bus_re", i),    32'(bus_re[i]),    32'(issue && !wwe[i]));
            chk($sformatf("i%0d_bus_addr", i),  32'(bus_addr[i]),  32'(e_addr[i]));
            chk($sformatf("i%0d_bus_wdata", i), bus_wdata[i],      e_wdata[i]);
            for (int k = 0; k < 2; k++) begin
                saw_ack[i][k] = issue && (int'(win[i]) == k);
                chk($sformatf("i%0d_m%0d_ack", i, k),    32'(m_ack[i][k]),    32'(saw_ack[i][k]));
                chk($sformatf("i%0d_m%0d_rvalid", i, k), 32'(m_rvalid[i][k]), 32'(done && int'(win[i]) == k));
                chk($sformatf("i%0d_m%0d_rdata", i, k),  m_rdata[i][k],      e_rdata[i][k]);
            end
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                model_reset(i);
            end else begin
                if (!wwe[i] && cyc == done_cyc[i] - 1)
                    e_rdata[i][int'(win[i])] = bus_rdata[i];
                if (cyc >= idle_cyc[i] && (m_req[i][0] || m_req[i][1])) begin
                    bit w;
                    w          = (m_req[i][0] && m_req[i][1]) ? !last[i] : m_req[i][1];
                    win[i]     = w;
                    last[i]    = w;
                    wwe[i]     = m_we[i][int'(w)];
                    e_addr[i]  = m_addr[i][int'(w)];
                    e_wdata[i] = m_wdata[i][int'(w)];
                    ack_cyc[i] = cyc + 1;
                    if (wwe[i]) begin
                        done_cyc[i] = -100;
                        idle_cyc[i] = cyc + 2;
                    end else begin
                        done_cyc[i] = cyc + 2 + lat[i];
                        idle_cyc[i] = cyc + 3 + lat[i];
                    end
                end
            end
        end
    endtask

    // Checks the current cycle, advances the model across the edge, and
    // returns 1 time unit into the next cycle.
    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            check_cycle();
        end else begin
            for (int i = 0; i < 2; i++) begin
                saw_ack[i][0] = 1'b0;
                saw_ack[i][1] = 1'b0;
            end
        end
        if (rst) rst_seen = 1'b1;
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        chk_en       = rst_seen;
        bus_rdata[0] = $urandom;
        bus_rdata[1] = $urandom;
    endtask

    task automatic set_both(input int k, input bit r, input bit we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        for (int i = 0; i < 2; i++) begin
            m_req[i][k]   = r;
            m_we[i][k]    = we;
            m_addr[i][k]  = a;
            m_wdata[i][k] = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        lat[0] = 1;
        lat[1] = 4;
        rst = 1'b1;
        set_both(0, 1'b0, 1'b0, '0, '0);
        set_both(1, 1'b0, 1'b0, '0, '0);
        bus_rdata[0] = '0;
        bus_rdata[1] = '0;
        model_reset(0);
        model_reset(1);
        step();
        step();
        rst = 1'b0;

        // m0 write: strobe and ack at T+1, idle at T+2
        set_both(0, 1'b1, 1'b1, 24'h000010, 32'hCECEFACE);
        step();
        chk("037_bus_we",   32'(bus_we[0]),   32'd1);
        chk("037_m0_ack",   32'(m_ack[0][0]), 32'd1);
        chk("037_bus_data", bus_wdata[0],     32'hCECEFACE);
        set_both(0, 1'b0, 1'b0, '0, '0);
        step();
        chk("037_busy_t2", 32'(busy[0]), 32'd0);

        // m1 read, RD_LAT=1: re at T+1, data at T+2, rvalid at T+3
        set_both(1, 1'b1, 1'b0, 24'h000100, '0);
        step();
        chk("038_bus_re", 32'(bus_re[0]), 32'd1);
        set_both(1, 1'b0, 1'b0, '0, '0);
        step();
        bus_rdata[0] = 32'h000000CC;
        step();
        chk("038_m1_rvalid", 32'(m_rvalid[0][1]), 32'd1);
        chk("038_m1_rdata",  m_rdata[0][1],       32'h000000CC);
        repeat (8) step();

        // both requesters hold writes: alternate grants, m0 first
        do_reset();
        set_both(0, 1'b1, 1'b1, 24'h000020, 32'h11111111);
        set_both(1, 1'b1, 1'b1, 24'h000030, 32'h22222222);
        repeat (8) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (m_ack[i][0]) g_seq[i].push_back(0);
                if (m_ack[i][1]) g_seq[i].push_back(1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("039_i%0d_ngrants", i), 32'(g_seq[i].size()), 32'd4);
            for (int j = 0; j < 4; j++)
                chk($sformatf("039_i%0d_grant%0d", i, j),
                    (j < g_seq[i].size()) ? 32'(g_seq[i][j]) : 32'hDEAD, 32'(j % 2));
        end
        set_both(0, 1'b0, 1'b0, '0, '0);
        set_both(1, 1'b0, 1'b0, '0, '0);
        repeat (8) step();

        // RD_LAT=4 read: busy 6 cycles, rvalid at T+6, m0 raised in WAIT granted at T+8
        do_reset();
        set_both(1, 1'b1, 1'b0, 24'h000040, '0);
        step();
        busy_cnt = busy[1] ? 1 : 0;
        rv_at    = -1;
        ack0_at  = -1;
        idle7    = 1'b1;
        set_both(1, 1'b0, 1'b0, '0, '0);
        step();
        set_both(0, 1'b1, 1'b1, 24'h000050, 32'h33333333);
        for (int t = 2; t <= 10; t++) begin
            if (t <= 7 && busy[1]) busy_cnt++;
            if (t == 7) idle7 = busy[1];
            if (m_rvalid[1][1] && rv_at < 0) rv_at = t;
            if (m_ack[1][0] && ack0_at < 0) begin
                ack0_at = t;
                set_both(0, 1'b0, 1'b0, '0, '0);
            end
            if (t < 10) step();
        end
        chk("040_busy_cycles", 32'(busy_cnt), 32'd6);
        chk("040_idle_t7",     32'(idle7),    32'd0);
        chk("040_rvalid_at",   32'(rv_at),    32'd6);
        chk("040_m0_ack_at",   32'(ack0_at),  32'd8);
        set_both(0, 1'b0, 1'b0, '0, '0);
        repeat (8) step();

        // reset during WAIT aborts the read
        do_reset();
        set_both(0, 1'b1, 1'b0, 24'h000060, '0);
        step();
        set_both(0, 1'b0, 1'b0, '0, '0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("041_busy",     32'(busy[1]),                32'd0);
        chk("041_bus_addr", 32'(bus_addr[1]),            32'd0);
        chk("041_strobes",  32'(bus_we[1] | bus_re[1]),  32'd0);
        chk("041_rdata",    m_rdata[1][0] | m_rdata[1][1], 32'd0);
        repeat (6) begin
            step();
            chk("041_no_rvalid", 32'(m_rvalid[1][0]), 32'd0);
        end

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if (!m_req[i][k] || saw_ack[i][k]) begin
                        m_req[i][k]   = ($urandom % 100) < 60;
                        m_we[i][k]    = $urandom % 2;
                        m_addr[i][k]  = AW'($urandom);
                        m_wdata[i][k] = $urandom;
                    end
                end
            end
            rst = ($urandom % 300) == 0;
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
